instr_mem: RTL and testbench
============================

INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 The block SHALL have parameter IW, default 9, instruction width in bits.
REQ-002 The block SHALL have parameter AW, default 12, address width; DEPTH = 2**AW words.
REQ-003 The block SHALL have parameter NOP_WORD, default all-zero IW bits, word returned for out-of-program fetches.
REQ-004 Ports SHALL be exactly as follows:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- ld_start  in  1  begin program load.
- ld_count  in  AW+1  number of words to load, sampled with ld_start.
- ld_valid  in  1  ld_data valid.
- ld_data  in  IW  program word.
- ld_ready  out  1  block accepts ld_data this cycle.
- ld_done  out  1  one-cycle pulse at load completion.
- fetch_en  in  1  fetch request.
- InstAddress  in  AW  fetch address.
- InstrOut  out  IW  registered instruction.
- instr_valid  out  1  InstrOut holds result of previous-cycle fetch.
- fetch_oob  out  1  previous fetch was at or beyond prog_len.
- prog_len  out  AW+1  words in currently loaded program.
- busy  out  1  load in progress.

Function
REQ-005 The block SHALL implement a 3-state FSM: EMPTY (no program), LOAD, RUN.
REQ-006 EMPTY or RUN with ld_start=1 SHALL go to LOAD next cycle; load counter cleared to 0; target = min(ld_count, DEPTH).
REQ-007 ld_start with ld_count=0 SHALL skip LOAD: go to RUN, prog_len=0, ld_done pulses next cycle.
REQ-008 In LOAD, ld_ready SHALL be 1; each cycle with ld_valid=1 writes ld_data to word[counter] and increments counter.
REQ-009 When the write of word target-1 occurs, FSM SHALL go to RUN next cycle, prog_len=target, ld_done=1 for exactly that cycle.
REQ-010 ld_start asserted while in LOAD SHALL be ignored.
REQ-011 ld_ready SHALL be 0 outside LOAD; ld_valid outside LOAD SHALL not write memory.
REQ-012 busy SHALL equal (state==LOAD).
REQ-013 In RUN, fetch_en=1 SHALL produce, on the next cycle, instr_valid=1 and InstrOut=word[InstAddress] if InstAddress<prog_len, else InstrOut=NOP_WORD and fetch_oob=1 (1-cycle latency).
REQ-014 fetch_en=0 in RUN SHALL give instr_valid=0, fetch_oob=0 next cycle; InstrOut holds its last value.
REQ-015 fetch_en in EMPTY or LOAD SHALL give instr_valid=0, fetch_oob=1 next cycle; InstrOut holds.
REQ-016 Fetch and write are never concurrent (fetch disabled in LOAD); no read-during-write hazard SHALL exist.
REQ-017 Memory words beyond prog_len SHALL retain prior contents but never be returned by a fetch.
REQ-018 ld_count > DEPTH SHALL saturate to DEPTH; counter SHALL never wrap.
REQ-019 A reload from RUN SHALL keep prog_len at its old value until the new ld_done cycle.

Reset
REQ-020 Reset_n=0 at a clock edge SHALL force: state=EMPTY, counter=0, prog_len=0, ld_ready=0, ld_done=0, busy=0, instr_valid=0, fetch_oob=0, InstrOut=NOP_WORD.
REQ-021 Memory array SHALL NOT be reset; reset during LOAD SHALL abort the load, leaving partial words written.
REQ-022 Reset SHALL take priority over ld_start and fetch_en in the same cycle.

Verification (IW=9, AW=4, NOP_WORD=0)
REQ-023 Reset, fetch_en=1 addr 0 -> next cycle instr_valid=0, fetch_oob=1, InstrOut=0.
REQ-024 ld_start, ld_count=3, words 0x1A5,0x0FF,0x101 with ld_valid gaps -> ld_done one pulse after third write, prog_len=3; fetch addr 1 -> next cycle InstrOut=0x0FF, instr_valid=1.
REQ-025 After REQ-024 fetch addr 3 -> InstrOut=0, fetch_oob=1, instr_valid=1.
REQ-026 ld_count=20 -> exactly 16 ld_ready handshakes accepted, prog_len=16; fetch addr 15 returns 16th word.
REQ-027 Reset_n low after 2 of 5 load words -> state EMPTY, prog_len=0, fetches return oob; new load of 1 word -> prog_len=1.
REQ-028 ld_start with ld_count=0 -> ld_done next cycle, prog_len=0, busy never 1; ld_start during LOAD -> counter and target unchanged.

Source files
------------

// File: rtl/instr_mem.sv
// instr_mem: loadable instruction store with a registered, bounds-checked fetch port
module instr_mem #(
  parameter int IW = 9,
  parameter int AW = 12,
  parameter logic [IW-1:0] NOP_WORD = '0
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          ld_start,
  input  logic [AW:0]   ld_count,
  input  logic          ld_valid,
  input  logic [IW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ld_done,
  input  logic          fetch_en,
  input  logic [AW-1:0] InstAddress,
  output logic [IW-1:0] InstrOut,
  output logic          instr_valid,
  output logic          fetch_oob,
  output logic [AW:0]   prog_len,
  output logic          busy
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;
  state_t        state_q;
  logic [AW:0]   cnt_q, tgt_q, prog_len_q, tgt_d;
  logic [IW-1:0] mem [2**AW];
  logic [IW-1:0] instr_q;
  logic          valid_q, oob_q, done_q;
  logic          wr_en, last_wr, in_prog, run_fetch;
  assign tgt_d     = ld_count > DEPTH ? DEPTH : ld_count;
  assign wr_en     = state_q == LOAD && ld_valid;
  assign last_wr   = wr_en && cnt_q + 1'b1 == tgt_q;
  assign in_prog   = {1'b0, InstAddress} < prog_len_q;
  assign run_fetch = fetch_en && state_q == RUN;
  // Load/run sequencing plus the registered fetch result; the old program stays visible until the new load completes
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= EMPTY;
      cnt_q      <= '0;
      tgt_q      <= '0;
      prog_len_q <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      oob_q      <= 1'b0;
      instr_q    <= NOP_WORD;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        LOAD: if (wr_en) begin
          cnt_q <= cnt_q + 1'b1;
          if (last_wr) begin
            state_q    <= RUN;
            prog_len_q <= tgt_q;
            done_q     <= 1'b1;
          end
        end
        default: if (ld_start) begin
          cnt_q <= '0;
          tgt_q <= tgt_d;
          if (tgt_d == '0) begin
            state_q    <= RUN;
            prog_len_q <= '0;
            done_q     <= 1'b1;
          end else state_q <= LOAD;
        end
      endcase
      valid_q <= run_fetch;
      oob_q   <= fetch_en && (state_q != RUN || !in_prog);
      if (run_fetch) instr_q <= in_prog ? mem[InstAddress] : NOP_WORD;
    end
  end
  // Program storage is never cleared; a write on a reset edge is dropped so an aborted load stops cleanly
  always_ff @(posedge Clk) begin
    if (Reset_n && wr_en) mem[cnt_q[AW-1:0]] <= ld_data;
  end
  assign ld_ready    = state_q == LOAD;
  assign busy        = state_q == LOAD;
  assign ld_done     = done_q;
  assign InstrOut    = instr_q;
  assign instr_valid = valid_q;
  assign fetch_oob   = oob_q;
  assign prog_len    = prog_len_q;
endmodule

// File: tb/tb_instr_mem.sv
// tb_instr_mem: directed table, corner sequences and random traffic against a word-level model
module tb_instr_mem;
  logic       Clk = 1'b0;
  logic       Reset_n, ld_start, ld_valid, fetch_en;
  logic [4:0] ld_count;
  logic [8:0] ld_data;
  logic [3:0] InstAddress;
  logic       ld_ready, ld_done, instr_valid, fetch_oob, busy;
  logic [8:0] InstrOut;
  logic [4:0] prog_len;
  int checks = 0;
  int errors = 0;

  instr_mem #(.IW(9), .AW(4), .NOP_WORD(9'h000)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ld_start(ld_start), .ld_count(ld_count),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done),
    .fetch_en(fetch_en), .InstAddress(InstAddress), .InstrOut(InstrOut),
    .instr_valid(instr_valid), .fetch_oob(fetch_oob), .prog_len(prog_len), .busy(busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Word-level reference: a program image, its length, and whether a load is pending
  int m_mem [16];
  int m_plen = 0, m_cnt = 0, m_tgt = 0;
  bit m_loading = 0, m_run = 0;
  int e_done = 0, e_valid = 0, e_oob = 0, e_instr = 0;

  task automatic model_step();
    int a;
    a = int'(InstAddress);
    if (!Reset_n) begin
      m_loading = 0; m_run = 0; m_plen = 0; m_cnt = 0;
      e_done = 0; e_valid = 0; e_oob = 0; e_instr = 0;
      return;
    end
    e_valid = int'(fetch_en && m_run);
    e_oob   = int'(fetch_en && (!m_run || a >= m_plen));
    if (fetch_en && m_run) e_instr = a < m_plen ? m_mem[a] : 0;
    e_done = 0;
    if (m_loading) begin
      if (ld_valid) begin
        m_mem[m_cnt] = int'(ld_data);
        m_cnt++;
        if (m_cnt == m_tgt) begin
          m_loading = 0; m_run = 1; m_plen = m_tgt; e_done = 1;
        end
      end
    end else if (ld_start) begin
      m_tgt = int'(ld_count) > 16 ? 16 : int'(ld_count);
      m_cnt = 0;
      if (m_tgt == 0) begin
        m_run = 1; m_plen = 0; e_done = 1;
      end else begin
        m_loading = 1; m_run = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge Clk);
    #1;
    chk("ld_ready", 32'(ld_ready), 32'(m_loading));
    chk("busy", 32'(busy), 32'(m_loading));
    chk("ld_done", 32'(ld_done), e_done);
    chk("instr_valid", 32'(instr_valid), e_valid);
    chk("fetch_oob", 32'(fetch_oob), e_oob);
    chk("InstrOut", 32'(InstrOut), e_instr);
    chk("prog_len", 32'(prog_len), m_plen);
  endtask

  task automatic idle();
    Reset_n = 1; ld_start = 0; ld_count = 0; ld_valid = 0; ld_data = 0;
    fetch_en = 0; InstAddress = 0;
  endtask

  typedef struct {
    int rst_n, st, cnt, vl, dat, fe, addr;
    int e_rdy, e_done, e_val, e_oob, e_instr, e_plen;
  } vec_t;
  vec_t vecs [15];

  initial begin
    int hs;
    bit done_seen;
    logic [8:0] last_word;
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    vecs[0]  = '{0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,     0};
    vecs[1]  = '{1, 0, 0, 0, 0,     1, 0, 0, 0, 0, 1, 0,     0};
    vecs[2]  = '{1, 1, 3, 0, 0,     0, 0, 1, 0, 0, 0, 0,     0};
    vecs[3]  = '{1, 0, 0, 1, 'h1A5, 0, 0, 1, 0, 0, 0, 0,     0};
    vecs[4]  = '{1, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0,     0};
    vecs[5]  = '{1, 1, 7, 1, 'h0FF, 0, 0, 1, 0, 0, 0, 0,     0};
    vecs[6]  = '{1, 0, 0, 0, 0,     1, 0, 1, 0, 0, 1, 0,     0};
    vecs[7]  = '{1, 0, 0, 1, 'h101, 0, 0, 0, 1, 0, 0, 0,     3};
    vecs[8]  = '{1, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,     3};
    vecs[9]  = '{1, 0, 0, 0, 0,     1, 1, 0, 0, 1, 0, 'h0FF, 3};
    vecs[10] = '{1, 0, 0, 0, 0,     1, 3, 0, 0, 1, 1, 0,     3};
    vecs[11] = '{1, 0, 0, 0, 0,     1, 2, 0, 0, 1, 0, 'h101, 3};
    vecs[12] = '{1, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 'h101, 3};
    vecs[13] = '{1, 0, 0, 1, 'h1FF, 0, 0, 0, 0, 0, 0, 'h101, 3};
    vecs[14] = '{1, 0, 0, 0, 0,     1, 0, 0, 0, 1, 0, 'h1A5, 3};
    idle();
    for (int i = 0; i < 15; i++) begin
      Reset_n = vecs[i].rst_n[0]; ld_start = vecs[i].st[0]; ld_count = 5'(vecs[i].cnt);
      ld_valid = vecs[i].vl[0]; ld_data = 9'(vecs[i].dat); fetch_en = vecs[i].fe[0];
      InstAddress = 4'(vecs[i].addr);
      cycle();
      chk($sformatf("tbl%0d ready", i), 32'(ld_ready), vecs[i].e_rdy);
      chk($sformatf("tbl%0d done", i), 32'(ld_done), vecs[i].e_done);
      chk($sformatf("tbl%0d valid", i), 32'(instr_valid), vecs[i].e_val);
      chk($sformatf("tbl%0d oob", i), 32'(fetch_oob), vecs[i].e_oob);
      chk($sformatf("tbl%0d instr", i), 32'(InstrOut), vecs[i].e_instr);
      chk($sformatf("tbl%0d plen", i), 32'(prog_len), vecs[i].e_plen);
    end
    idle(); ld_start = 1; ld_count = 5'd20;
    cycle();
    idle();
    hs = 0; done_seen = 0; last_word = '0;
    for (int i = 0; i < 200 && !done_seen; i++) begin
      ld_valid = 1'($urandom_range(0, 1)); ld_data = 9'($urandom);
      if (ld_valid && ld_ready) begin hs++; last_word = ld_data; end
      cycle();
      if (ld_done) done_seen = 1;
    end
    chk("sat done seen", 32'(done_seen), 1);
    chk("sat handshakes", hs, 16);
    chk("sat prog_len", 32'(prog_len), 16);
    ld_valid = 1; ld_data = 9'h1C3;
    cycle();
    chk("sat ready after", 32'(ld_ready), 0);
    idle(); fetch_en = 1; InstAddress = 4'd15;
    cycle();
    chk("sat word15", 32'(InstrOut), 32'(last_word));
    idle(); ld_start = 1; ld_count = 5'd5;
    cycle();
    idle(); ld_valid = 1; ld_data = 9'h055;
    cycle();
    ld_data = 9'h0AA;
    cycle();
    idle(); Reset_n = 0; fetch_en = 1; ld_start = 1; ld_count = 5'd2;
    cycle();
    chk("abort busy", 32'(busy), 0);
    chk("abort plen", 32'(prog_len), 0);
    idle(); fetch_en = 1;
    cycle();
    chk("abort oob", 32'(fetch_oob), 1);
    chk("abort valid", 32'(instr_valid), 0);
    idle(); ld_start = 1; ld_count = 5'd1;
    cycle();
    idle(); ld_valid = 1; ld_data = 9'h133;
    cycle();
    chk("reload done", 32'(ld_done), 1);
    chk("reload plen", 32'(prog_len), 1);
    idle(); fetch_en = 1;
    cycle();
    chk("reload word", 32'(InstrOut), 'h133);
    idle(); ld_start = 1; ld_count = 5'd0;
    cycle();
    chk("zero done", 32'(ld_done), 1);
    chk("zero plen", 32'(prog_len), 0);
    chk("zero busy", 32'(busy), 0);
    idle(); fetch_en = 1;
    cycle();
    chk("zero done low", 32'(ld_done), 0);
    chk("zero oob", 32'(fetch_oob), 1);
    chk("zero valid", 32'(instr_valid), 1);
    for (int i = 0; i < 3000; i++) begin
      Reset_n = $urandom_range(0, 99) != 0;
      ld_start = $urandom_range(0, 19) == 0;
      ld_count = 5'($urandom_range(0, 20));
      ld_valid = 1'($urandom_range(0, 1));
      ld_data = 9'($urandom);
      fetch_en = $urandom_range(0, 9) < 6;
      InstAddress = 4'($urandom);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
